instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  RV32I instruction encoder: packs format/opcode/funct/register/immediate fields into
//  32-bit instruction words, the inverse of the decode stage. Feeds a boot/test program
//  loader that writes instruction memory; also used by benches to generate decoder stimulus.
//  Registered output, valid/ready on both sides, running word-address counter, error flagging.
// PARAMETERS
//  ADDR_WIDTH  32   width of out_addr
//  BASE_ADDR   0    out_addr value after reset or addr_clr (word aligned)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   field bundle valid
//  in_ready   out  1   encoder can accept bundle this cycle
//  fmt        in   3   0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//  opcode     in   7   instr[6:0]
//  funct3     in   3   instr[14:12] (R/I/S/B)
//  funct7     in   7   instr[31:25] (R, I-shift)
//  rd/rs1/rs2 in   5   register addresses (unused ones ignored)
//  imm        in   32  full signed immediate value (U: full value, low 12 bits must be 0)
//  addr_clr   in   1   synchronous return of out_addr to BASE_ADDR
//  out_valid  out  1   out_instr/out_addr/out_err valid
//  out_ready  in   1   consumer accepts output word
//  out_instr  out  32  encoded instruction
//  out_addr   out  ADDR_WIDTH  byte address of this word
//  out_err    out  1   immediate not representable / illegal fmt for this word
//  err_cnt    out  8   saturating count of accepted words with out_err=1
// BEHAVIOUR
//  Reset: out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_cnt=0.
//  in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
//  Latency 1: accepted bundle appears on outputs next cycle with out_valid=1.
//  Output regs hold stable while out_valid && !out_ready; no accept in that case.
//  Output handshake (out_valid && out_ready) with no accept -> out_valid=0 next cycle.
//  Handshake and accept same cycle -> new word loaded, out_valid stays 1 (full throughput).
//  out_addr += 4 on each output handshake; wraps modulo 2^ADDR_WIDTH.
//  addr_clr: next out_addr=BASE_ADDR; wins over simultaneous handshake increment.
//   If a word is pending it is re-addressed; handshake completing that cycle still pops it.
//  Encodings:
//   R: {funct7,rs2,rs1,funct3,rd,opcode}
//   I: {imm[11:0],rs1,funct3,rd,opcode}; shift (opcode 0010011, funct3 001/101):
//      {funct7,imm[4:0],rs1,funct3,rd,opcode}
//   S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
//   B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
//   U: {imm[31:12],rd,opcode}
//   J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
//  Error rules (word still emitted with truncated fields, out_err=1):
//   I/S: imm[31:11] not all equal; I-shift: imm outside 0..31
//   B: imm[31:12] not all equal or imm[0]=1; J: imm[31:20] not all equal or imm[0]=1
//   U: imm[11:0]!=0; fmt 6/7: out_instr=32'h0000_0013 (NOP)
//  err_cnt increments on output handshake with out_err=1, saturates at 255; addr_clr clears it.
//  Reset asserted mid-transfer drops pending word immediately; no partial output.
// TESTING
//  I addi rd=1 rs1=0 f3=0 imm=5 op=0x13 -> out_instr=0x00500093, err=0, addr=BASE_ADDR
//  R add rd=3 rs1=1 rs2=2 op=0x33 f7=0, then S sw rs1=1 rs2=2 f3=2 imm=8 op=0x23
//   back-to-back, out_ready=1 -> 0x002081B3 @0, 0x0020A423 @4, one word per cycle
//  B beq rs1=1 rs2=2 imm=-4 op=0x63 -> 0xFE208EE3; J jal rd=1 imm=0x800 op=0x6F -> 0x001000EF
//  I imm=2048 -> out_instr=0x80000093, out_err=1, err_cnt 0->1 on handshake; B imm=3 -> err=1
//  out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_instr/out_addr stable,
//   addr increments exactly once when out_ready rises
//  addr_clr during handshake at addr=0x10 -> next out_addr=BASE_ADDR, err_cnt=0;
//   rst_n low mid-stream -> out_valid=0 asynchronously, addr=BASE_ADDR

Source files
------------

// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if : field-bundle input, encoded-word output and address control
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            fmt;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [31:0]           imm;
  logic                  addr_clr;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_err;
  logic [7:0]            err_cnt;

  modport master (
    output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
    output addr_clr, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
    input  addr_clr, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder : RV32I field bundle to 32-bit word, registered valid/ready output
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_encoder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_encoder_if.slave   bus
);

  localparam logic [2:0]  c_FMT_R    = 3'd0;
  localparam logic [2:0]  c_FMT_I    = 3'd1;
  localparam logic [2:0]  c_FMT_S    = 3'd2;
  localparam logic [2:0]  c_FMT_B    = 3'd3;
  localparam logic [2:0]  c_FMT_U    = 3'd4;
  localparam logic [2:0]  c_FMT_J    = 3'd5;
  localparam logic [6:0]  c_OP_IMM   = 7'b0010011;
  localparam logic [2:0]  c_F3_SLL   = 3'b001;
  localparam logic [2:0]  c_F3_SR    = 3'b101;
  localparam logic [31:0] c_NOP      = 32'h0000_0013;
  localparam logic [7:0]  c_ERR_MAX  = 8'hFF;
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_STEP = ADDR_WIDTH'(4);

  logic                  valid_q,   valid_d;
  logic [31:0]           instr_q,   instr_d;
  logic                  err_q,     err_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic        w_accept;
  logic        w_out_hs;
  logic [31:0] w_imm;
  logic        w_is_shift;
  logic        w_fits_i;
  logic        w_fits_b;
  logic        w_fits_j;
  logic        w_shamt_ok;
  logic [31:0] w_word_r;
  logic [31:0] w_word_i;
  logic [31:0] w_word_sh;
  logic [31:0] w_word_s;
  logic [31:0] w_word_b;
  logic [31:0] w_word_u;
  logic [31:0] w_word_j;
  logic [31:0] w_instr;
  logic        w_err;

  assign w_imm    = bus.imm;
  assign w_out_hs = valid_q && bus.out_ready;
  assign w_accept = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = !valid_q || bus.out_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_err   = err_q;
  assign bus.out_addr  = addr_q;
  assign bus.err_cnt   = err_cnt_q;

  // A signed value fits N bits when every bit above N-1 matches the sign bit.
  assign w_fits_i   = (&w_imm[31:11]) || !(|w_imm[31:11]);
  assign w_fits_b   = (&w_imm[31:12]) || !(|w_imm[31:12]);
  assign w_fits_j   = (&w_imm[31:20]) || !(|w_imm[31:20]);
  assign w_shamt_ok = !(|w_imm[31:5]);

  assign w_is_shift = (bus.opcode == c_OP_IMM) &&
                      ((bus.funct3 == c_F3_SLL) || (bus.funct3 == c_F3_SR));

  assign w_word_r  = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
  assign w_word_i  = {w_imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
  assign w_word_sh = {bus.funct7, w_imm[4:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
  assign w_word_s  = {w_imm[11:5], bus.rs2, bus.rs1, bus.funct3, w_imm[4:0], bus.opcode};
  assign w_word_b  = {w_imm[12], w_imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                      w_imm[4:1], w_imm[11], bus.opcode};
  assign w_word_u  = {w_imm[31:12], bus.rd, bus.opcode};
  assign w_word_j  = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.rd, bus.opcode};

  // Illegal formats fall through to a NOP flagged as an error.
  always_comb begin
    w_instr = c_NOP;
    w_err   = 1'b1;
    case (bus.fmt)
      c_FMT_R: begin
        w_instr = w_word_r;
        w_err   = 1'b0;
      end
      c_FMT_I: begin
        if (w_is_shift) begin
          w_instr = w_word_sh;
          w_err   = !w_shamt_ok;
        end else begin
          w_instr = w_word_i;
          w_err   = !w_fits_i;
        end
      end
      c_FMT_S: begin
        w_instr = w_word_s;
        w_err   = !w_fits_i;
      end
      c_FMT_B: begin
        w_instr = w_word_b;
        w_err   = !w_fits_b || w_imm[0];
      end
      c_FMT_U: begin
        w_instr = w_word_u;
        w_err   = |w_imm[11:0];
      end
      c_FMT_J: begin
        w_instr = w_word_j;
        w_err   = !w_fits_j || w_imm[0];
      end
      default: begin
        w_instr = c_NOP;
        w_err   = 1'b1;
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    err_d   = err_q;
    if (w_accept) begin
      valid_d = 1'b1;
      instr_d = w_instr;
      err_d   = w_err;
    end else if (w_out_hs) begin
      valid_d = 1'b0;
    end
  end

  // Clear beats the handshake increment; a pending word simply gets re-addressed.
  always_comb begin
    addr_d    = addr_q;
    err_cnt_d = err_cnt_q;
    if (bus.addr_clr) begin
      addr_d    = BASE_ADDR;
      err_cnt_d = 8'd0;
    end else if (w_out_hs) begin
      addr_d = addr_q + c_ADDR_STEP;
      if (err_q && (err_cnt_q != c_ERR_MAX)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      instr_q   <= 32'd0;
      err_q     <= 1'b0;
      addr_q    <= BASE_ADDR;
      err_cnt_q <= 8'd0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (valid_q && !bus.out_ready) |=> (valid_q && $stable(instr_q) && $stable(err_q)));

  a_addr_aligned : assert property (@(posedge clk) disable iff (!rst_n)
    (addr_q[1:0] == BASE_ADDR[1:0]));
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder : vector table, hand sequences and randomized model comparison
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instr_encoder;

  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_WIDTH(AW)) vif ();

  instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif.slave)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_vec(input vec_t v);
    vif.fmt    = v.fmt;
    vif.opcode = v.op;
    vif.funct3 = v.f3;
    vif.funct7 = v.f7;
    vif.rd     = v.rd;
    vif.rs1    = v.rs1;
    vif.rs2    = v.rs2;
    vif.imm    = v.imm;
  endtask

  task automatic do_reset();
    vif.in_valid  = 1'b0;
    vif.addr_clr  = 1'b0;
    vif.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reference encoder written from the field-placement rules with integer arithmetic.
  function automatic void ref_enc(input int f, input int op, input int f3, input int f7,
                                  input int rd, input int rs1, input int rs2, input int imm,
                                  output logic [31:0] w, output logic e);
    int base;
    base = (rs1 << 15) | (f3 << 12) | op;
    case (f)
      0: begin w = (f7 << 25) | (rs2 << 20) | base | (rd << 7); e = 1'b0; end
      1: begin
        if (op == 19 && (f3 == 1 || f3 == 5)) begin
          w = (f7 << 25) | ((imm & 31) << 20) | base | (rd << 7);
          e = (imm < 0) || (imm > 31);
        end else begin
          w = ((imm & 4095) << 20) | base | (rd << 7);
          e = (imm < -2048) || (imm > 2047);
        end
      end
      2: begin
        w = (((imm >>> 5) & 127) << 25) | (rs2 << 20) | base | ((imm & 31) << 7);
        e = (imm < -2048) || (imm > 2047);
      end
      3: begin
        w = (((imm >>> 12) & 1) << 31) | (((imm >>> 5) & 63) << 25) | (rs2 << 20) | base
          | (((imm >>> 1) & 15) << 8) | (((imm >>> 11) & 1) << 7);
        e = (imm < -4096) || (imm > 4095) || ((imm & 1) != 0);
      end
      4: begin
        w = (imm & 32'hFFFF_F000) | (rd << 7) | op;
        e = (imm & 4095) != 0;
      end
      5: begin
        w = (((imm >>> 20) & 1) << 31) | (((imm >>> 1) & 1023) << 21)
          | (((imm >>> 11) & 1) << 20) | (((imm >>> 12) & 255) << 12) | (rd << 7) | op;
        e = (imm < -1048576) || (imm > 1048575) || ((imm & 1) != 0);
      end
      default: begin w = 32'h0000_0013; e = 1'b1; end
    endcase
  endfunction

  vec_t tbl [15];
  vec_t v_add, v_sw, v_addi, v_bad;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_addr;
    logic [31:0] exp_cnt;
    logic        m_valid;
    logic [31:0] m_instr;
    logic        m_err;
    logic [31:0] m_addr;
    int          m_cnt;
    int          bounds [19];

    //          fmt  op      f3    f7     rd    rs1   rs2   imm            exp_instr      err
    tbl[0]  = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,         32'h0050_0093, 1'b0};
    tbl[1]  = '{3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,         32'h0020_81B3, 1'b0};
    tbl[2]  = '{3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_A423, 1'b0};
    tbl[3]  = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0};
    tbl[4]  = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0};
    tbl[5]  = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h8000_0093, 1'b1};
    tbl[6]  = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3,         32'h0020_8163, 1'b1};
    tbl[7]  = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    tbl[8]  = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1};
    tbl[9]  = '{3'd6, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,         32'h0000_0013, 1'b1};
    tbl[10] = '{3'd1, 7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd3,         32'h0030_9093, 1'b0};
    tbl[11] = '{3'd1, 7'h13, 3'd5, 7'h20, 5'd2, 5'd3, 5'd0, 32'd32,        32'h4001_D113, 1'b1};
    tbl[12] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd1,         32'h0000_006F, 1'b1};
    tbl[13] = '{3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd0, 5'd0, 32'd2048,      32'h8000_2023, 1'b1};
    tbl[14] = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0};

    v_addi = tbl[0];
    v_add  = tbl[1];
    v_sw   = tbl[2];
    v_bad  = tbl[9];
    v_bad.fmt = 3'd7;

    bounds = '{2047, 2048, -2048, -2049, 4095, 4096, -4096, -4097, 31, 32, 0, -1,
               1048575, 1048576, -1048576, -1048577, 4096, 32'h7FFF_F000, 3};

    set_vec(v_addi);
    vif.in_valid  = 1'b0;
    vif.addr_clr  = 1'b0;
    vif.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    chk("reset out_valid", 32'(vif.out_valid), 32'd0);
    chk("reset out_instr", vif.out_instr, 32'd0);
    chk("reset out_err",   32'(vif.out_err), 32'd0);
    chk("reset out_addr",  vif.out_addr, BASE);
    chk("reset err_cnt",   32'(vif.err_cnt), 32'd0);
    chk("reset in_ready",  32'(vif.in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back R then S with the consumer always ready.
    vif.out_ready = 1'b1;
    set_vec(v_add);
    vif.in_valid = 1'b1;
    step();
    chk("b2b add instr", vif.out_instr, 32'h0020_81B3);
    chk("b2b add addr",  vif.out_addr, BASE);
    set_vec(v_sw);
    step();
    chk("b2b sw valid", 32'(vif.out_valid), 32'd1);
    chk("b2b sw instr", vif.out_instr, 32'h0020_A423);
    chk("b2b sw addr",  vif.out_addr, BASE + 32'd4);
    vif.in_valid = 1'b0;
    step();
    chk("b2b drain valid", 32'(vif.out_valid), 32'd0);
    chk("b2b drain addr",  vif.out_addr, BASE + 32'd8);

    exp_addr = BASE + 32'd8;
    exp_cnt  = 32'd0;
    for (int i = 0; i < 15; i++) begin
      set_vec(tbl[i]);
      vif.in_valid = 1'b1;
      step();
      vif.in_valid = 1'b0;
      chk($sformatf("tbl[%0d] valid", i), 32'(vif.out_valid), 32'd1);
      chk($sformatf("tbl[%0d] instr", i), vif.out_instr, tbl[i].exp_instr);
      chk($sformatf("tbl[%0d] err",   i), 32'(vif.out_err), 32'(tbl[i].exp_err));
      chk($sformatf("tbl[%0d] addr",  i), vif.out_addr, exp_addr);
      step();
      exp_addr = exp_addr + 32'd4;
      if (tbl[i].exp_err) exp_cnt = exp_cnt + 32'd1;
      chk($sformatf("tbl[%0d] err_cnt", i), 32'(vif.err_cnt), exp_cnt);
    end

    // Backpressure: word held, no new accept, exactly one address step per pop.
    vif.out_ready = 1'b0;
    set_vec(v_addi);
    vif.in_valid = 1'b1;
    step();
    set_vec(v_add);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d in_ready", k), 32'(vif.in_ready), 32'd0);
      chk($sformatf("bp%0d instr", k), vif.out_instr, 32'h0050_0093);
      chk($sformatf("bp%0d addr",  k), vif.out_addr, exp_addr);
      step();
    end
    vif.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(vif.in_ready), 32'd1);
    step();
    vif.in_valid = 1'b0;
    chk("bp next instr", vif.out_instr, 32'h0020_81B3);
    chk("bp next addr",  vif.out_addr, exp_addr + 32'd4);
    step();
    chk("bp drain valid", 32'(vif.out_valid), 32'd0);
    chk("bp drain addr",  vif.out_addr, exp_addr + 32'd8);

    // addr_clr during a handshake with the pending word at 0x10.
    do_reset();
    vif.out_ready = 1'b1;
    set_vec(v_bad);
    vif.in_valid = 1'b1;
    repeat (5) step();
    vif.in_valid = 1'b0;
    chk("clr pre addr",    vif.out_addr, BASE + 32'h10);
    chk("clr pre err_cnt", 32'(vif.err_cnt), 32'd4);
    vif.addr_clr = 1'b1;
    step();
    vif.addr_clr = 1'b0;
    chk("clr addr",    vif.out_addr, BASE);
    chk("clr err_cnt", 32'(vif.err_cnt), 32'd0);
    chk("clr popped",  32'(vif.out_valid), 32'd0);

    // err_cnt saturation.
    do_reset();
    vif.out_ready = 1'b1;
    set_vec(v_bad);
    vif.in_valid = 1'b1;
    repeat (255) step();
    chk("sat err_cnt 254", 32'(vif.err_cnt), 32'd254);
    chk("sat nop instr",   vif.out_instr, 32'h0000_0013);
    repeat (3) step();
    vif.in_valid = 1'b0;
    step();
    chk("sat err_cnt 255", 32'(vif.err_cnt), 32'd255);
    chk("sat addr",        vif.out_addr, BASE + 32'd1032);

    // Asynchronous reset with a word pending.
    vif.out_ready = 1'b0;
    set_vec(v_add);
    vif.in_valid = 1'b1;
    step();
    chk("arst pre valid", 32'(vif.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", 32'(vif.out_valid), 32'd0);
    chk("arst out_addr",  vif.out_addr, BASE);
    chk("arst err_cnt",   32'(vif.err_cnt), 32'd0);
    @(negedge clk);
    vif.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic against the reference model.
    do_reset();
    m_valid = 1'b0;
    m_instr = 32'd0;
    m_err   = 1'b0;
    m_addr  = BASE;
    m_cnt   = 0;
    for (int c = 0; c < 600; c++) begin
      int f, op, f3, f7, rd, rs1, rs2, imm;
      logic iv, ordy, clr, exp_rdy, hs, acc, e;
      logic [31:0] w;

      chk("rnd out_valid", 32'(vif.out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rnd out_instr", vif.out_instr, m_instr);
        chk("rnd out_err",   32'(vif.out_err), 32'(m_err));
      end
      chk("rnd out_addr", vif.out_addr, m_addr);
      chk("rnd err_cnt",  32'(vif.err_cnt), 32'(m_cnt));

      iv   = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      clr  = ($urandom % 60) == 0;
      f    = int'($urandom_range(0, 7));
      op   = (($urandom % 2) != 0) ? 19 : int'($urandom % 128);
      f3   = int'($urandom % 8);
      f7   = int'($urandom % 128);
      rd   = int'($urandom % 32);
      rs1  = int'($urandom % 32);
      rs2  = int'($urandom % 32);
      case ($urandom % 4)
        0:       imm = int'($urandom_range(0, 63)) - 32;
        1:       imm = bounds[$urandom % 19];
        2:       imm = int'($urandom);
        default: imm = int'($urandom & 32'hFFFF_F000);
      endcase

      vif.in_valid  = iv;
      vif.out_ready = ordy;
      vif.addr_clr  = clr;
      vif.fmt    = 3'(f);
      vif.opcode = 7'(op);
      vif.funct3 = 3'(f3);
      vif.funct7 = 7'(f7);
      vif.rd     = 5'(rd);
      vif.rs1    = 5'(rs1);
      vif.rs2    = 5'(rs2);
      vif.imm    = imm;
      #1;
      exp_rdy = !m_valid || ordy;
      chk("rnd in_ready", 32'(vif.in_ready), 32'(exp_rdy));

      hs  = m_valid && ordy;
      acc = iv && exp_rdy;
      if (clr) m_cnt = 0;
      else if (hs && m_err && m_cnt < 255) m_cnt = m_cnt + 1;
      if (clr) m_addr = BASE;
      else if (hs) m_addr = m_addr + 32'd4;
      if (acc) begin
        ref_enc(f, op, f3, f7, rd, rs1, rs2, imm, w, e);
        m_valid = 1'b1;
        m_instr = w;
        m_err   = e;
      end else if (hs) begin
        m_valid = 1'b0;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
